sevenseg_scan_ctrl: RTL
=======================

Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the Nexys3 4-digit common-anode seven-segment display.
- Runs in the 24 MHz domain beside the clock divider block.
- Sequences anodes at 1 kHz per digit, decodes a 16-bit hex value with per-digit decimal points, and applies leading-zero blanking.
- Double-buffers host updates so a new value takes effect only at a frame boundary, which avoids display tearing.

Parameters:
- DIG_PERIOD, 24000: clk_24M cycles per digit slot (1 kHz digit rate, 250 Hz frame rate).
- BLANK_CYCLES, 240: cycles at the start of each slot with all anodes off, for anti-ghosting. Must be less than DIG_PERIOD.
- ZERO_BLANK, 1: 1 enables leading-zero blanking.

Ports:
- clk_24M  in  1  24 MHz system clock
- reset  in  1  synchronous, active-high
- load  in  1  single-cycle strobe; captures value and dp_in
- value  in  16  four hex nibbles; [3:0] is digit 0 (rightmost)
- dp_in  in  4  decimal point request per digit, active-high
- digit_en  in  4  live per-digit enable; 0 forces that digit dark
- load_pending  out  1  high while a captured load awaits its frame boundary
- an  out  4  anode drives, active-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset values:
  - slot counter cnt=0, digit index idx=0.
  - active and pending registers = 0; pending flag = 0.
  - an=4'b1111, seg=7'b1111111, dp=1, frame_done=0, load_pending=0.
- Counter and index:
  - cnt counts 0..DIG_PERIOD-1 and wraps to 0.
  - At terminal count (cnt==DIG_PERIOD-1), idx advances 0→1→2→3→0.
- Frame boundary: terminal count while idx==3. frame_done is registered and is high the cycle after the boundary.
- Load handshake:
  - load=1 writes value/dp_in into the pending registers and sets the pending flag.
  - A later load before the boundary overwrites pending (last write wins).
  - At a boundary with the flag set, pending is copied to active and the flag clears.
  - If load coincides with a boundary, the incoming value goes directly to active and the flag clears.
  - load_pending reflects the flag, registered.
- Output generation, registered one cycle after cnt/idx:
  - Blank window: if cnt < BLANK_CYCLES, then an=1111, seg=1111111, dp=1.
  - Otherwise an = one-hot-low on idx (idx 0 → 4'b1110), unless the digit is suppressed. A suppressed digit gives an=1111.
  - Suppression conditions: digit_en[idx]==0, or leading-zero blanked.
- Leading-zero blanking (ZERO_BLANK=1):
  - Digit k (k=3..1) is blanked if its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - A digit with a dp request is never blanked, and neither is any digit below it.
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - dp = ~active_dp[idx] when the digit is lit.
- digit_en is not buffered; it takes effect in the next slot output cycle.
- Reset mid-frame returns to the reset state next cycle and discards any pending load.

Test Plan:
- Bench override DIG_PERIOD=16, BLANK_CYCLES=2 for all scenarios.
- Reset release, no load → an stays 1111 in blank windows and cycles 1110/1101/1011/0111 otherwise. seg=1000000 only while an=1110; digits 3..1 are dark. frame_done pulses every 64 cycles.
- load with value=16'h1A8F, dp_in=4'b0100 mid-frame → load_pending=1 until the boundary. Next frame shows digit0=0001110 (F), digit1=0000000 (8), digit2=0001000 with dp=0 (A), digit3=1111001 (1).
- Two loads (16'h0001, then 16'h0023) within one frame → only 0023 is displayed. Digits 3 and 2 are dark, digit1=0100100, digit0=0110000.
- load of 16'h00F0 asserted exactly on the boundary cycle → no pending phase. The new value is active in the next frame and load_pending stays 0.
- digit_en=4'b1011 with value 16'h8888 → an never equals 1011; the other three digits show 0000000.
- reset asserted mid-slot with a load pending → next cycle: an=1111, load_pending=0, cnt=0. After release the display shows 0.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment display.
// Decodes a double-buffered 16-bit hex value with per-digit decimal points and leading-zero blanking.
module sevenseg_scan_ctrl #(
  parameter int DIG_PERIOD   = 24000,
  parameter int BLANK_CYCLES = 240,
  parameter bit ZERO_BLANK   = 1'b1
) (
  input  logic        clk_24M,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  output logic        load_pending,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (DIG_PERIOD > 1) ? $clog2(DIG_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIG_PERIOD - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          term;
  logic          boundary;

  logic [15:0]   act_val;
  logic [3:0]    act_dp;
  logic [15:0]   pend_val;
  logic [3:0]    pend_dp;
  logic          pend_flag;

  logic [3:0]    lz_blank;
  logic          higher_clear;
  logic [3:0]    nib;
  logic          lit;
  logic [3:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  assign term     = (cnt == CNT_LAST);
  assign boundary = term && (idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_24M) begin
    if (reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (term) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // NOTE: the value buffers are reset too, so the display shows a defined 0 rather than garbage after reset.
  always_ff @(posedge clk_24M) begin
    if (reset) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else if (boundary) begin
      // A load landing on the boundary bypasses the pending stage entirely.
      if (load) begin
        act_val <= value;
        act_dp  <= dp_in;
      end else if (pend_flag) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      pend_flag <= 1'b0;
    end else if (load) begin
      pend_val  <= value;
      pend_dp   <= dp_in;
      pend_flag <= 1'b1;
    end
  end

  assign load_pending = pend_flag;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lz_blank     = 4'b0000;
    higher_clear = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      higher_clear = higher_clear && (act_val[k*4 +: 4] == 4'h0) && !act_dp[k];
      lz_blank[k]  = ZERO_BLANK && higher_clear;
    end
  end

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    nib     = act_val[{idx, 2'b00} +: 4];
    lit     = (cnt >= CNT_BLANK) && digit_en[idx] && !lz_blank[idx];
    if (lit) begin
      an_nxt  = ~(4'b0001 << idx);
      seg_nxt = hex_to_seg(nib);
      dp_nxt  = ~act_dp[idx];
    end
  end

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule
